hamming_acc_param: RTL and testbench
====================================

Name: hamming_acc_param

Overview:
- Parametrised, streaming Hamming-distance accumulator. Successor to the fixed 32-bit, 1-bit-per-cycle serial Hamming block.
- Consumes W bits per beat from each party (g_input, e_input) over N/W valid beats. Accumulates popcount(g XOR e) into a registered count.
- Adds start/valid/done session control, so a host-side sequencer can run back-to-back comparisons without a global reset.

Parameters:
- N, 32, total bits compared per session. Must be divisible by W; a static check fails elaboration otherwise.
- W, 1, bits consumed per beat (1..N).
- Derived local CC = N/W (beats per session), OW = clog2(N+1) (result width), BW = clog2(CC+1) (beat counter width).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle pulse: clear and begin a new session.
- in_valid  in  1  current beat is valid; sampled only in ACCUM.
- g_input  in  W  garbler-side bits for this beat.
- e_input  in  W  evaluator-side bits for this beat.
- o  out  OW  accumulated Hamming distance (registered).
- busy  out  1  high in ACCUM.
- done  out  1  high in DONE; o is final.

Behaviour:
- Reset (rst=0, async): state=IDLE, o=0, beat counter=0, busy=0, done=0. Reset takes effect immediately, including mid-session; the partial count is discarded.
- States:
  - IDLE -> ACCUM on start.
  - ACCUM -> DONE on the valid beat where beat counter = CC-1.
  - DONE -> ACCUM on start. Otherwise DONE holds indefinitely.
- start (any state): next cycle state=ACCUM, o=0, counter=0, done=0. A start that coincides with in_valid discards that beat.
  - In ACCUM, start aborts the session and restarts cleanly.
- ACCUM, in_valid=1:
  - o <= o + popcount(g_input XOR e_input). Popcount is W-wide, zero-extended to OW.
  - counter <= counter+1.
- ACCUM, in_valid=0: o and counter hold. Gaps of any length are legal.
- Last beat: o holds the final sum, and done=1 / busy=0, in the cycle after the edge that sampled beat CC-1. Latency is 1 cycle from the final valid beat.
- in_valid outside ACCUM is ignored. o holds its value in IDLE and DONE.
- Overflow is impossible: max sum = N < 2^OW. The adder is OW bits wide and must not saturate or wrap.
- W=N (CC=1): a single valid beat completes the session.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: HAMMING_ACC_THRESH_EN.
- Defined:
  - Adds input port thresh [OW-1:0] and output port match [0:0].
  - match is registered: match <= (final o <= thresh), updated on the same edge that enters DONE.
  - thresh is sampled on that edge; match is held through DONE.
  - match is cleared to 0 by reset and by start.
- Undefined: thresh, match and the compare logic are absent. Behaviour is otherwise identical.

Test Plan:
- N=32,W=1: start, 32 valid beats with g=e -> o=0, done=1 one cycle after beat 32, busy=0.
- N=32,W=1: 32 beats with g=1,e=0 -> o=32 (6'b100000). Alternating-bit pattern (16 differing bits) -> o=16.
- N=32,W=8: beats g/e = 8'hFF/8'h00, 8'h0F/8'h00, 8'hAA/8'hAA, 8'h01/8'h00 -> o=13, done after the 4th valid beat. Insert 3 in_valid=0 cycles between beats 2 and 3 -> same o=13, done delayed by 3 cycles.
- N=32,W=8: start, 2 beats of 8'hFF/8'h00, then start again with in_valid=1 that cycle -> o=0, counter=0. Four further beats of 8'h01/8'h00 -> o=4. The discarded beat must not count.
- Reset mid-session: rst=0 asynchronously after 2 beats -> o=0, busy=0, done=0 before the next clock edge. Subsequent full session is unaffected.
- With HAMMING_ACC_THRESH_EN, N=32,W=1:
  - distance 10, thresh=10 -> match=1.
  - distance 11, thresh=10 -> match=0.
  - match returns to 0 on the next start.

Source files
------------

// File: rtl/hamming_acc_param_if.sv
// Session/beat bundle for hamming_acc_param. With HAMMING_ACC_THRESH_EN defined it
// also carries the threshold input and the registered match flag.
interface hamming_acc_param_if #(
  parameter int N = 32,
  parameter int W = 1
);
  localparam int OW = $clog2(N + 1);

  // Handshake: start is a one-cycle pulse, and in_valid qualifies g_input/e_input only while busy.
  // There is no back-pressure. o is final whenever done is high.
  logic          start;
  logic          in_valid;
  logic [W-1:0]  g_input;
  logic [W-1:0]  e_input;
  logic [OW-1:0] o;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;
`ifdef HAMMING_ACC_THRESH_EN
  logic [OW-1:0] thresh;
  logic          match;

  modport master (
    output start, in_valid, g_input, e_input, thresh,
    input  o, busy, done, state_dbg, match
  );
  modport slave (
    input  start, in_valid, g_input, e_input, thresh,
    output o, busy, done, state_dbg, match
  );
`else
  modport master (
    output start, in_valid, g_input, e_input,
    input  o, busy, done, state_dbg
  );
  modport slave (
    input  start, in_valid, g_input, e_input,
    output o, busy, done, state_dbg
  );
`endif
endinterface

// File: rtl/hamming_acc_param.sv
// Streaming Hamming-distance accumulator: W bits per valid beat, N/W beats per session.
// Optional threshold compare enabled by defining HAMMING_ACC_THRESH_EN.
module hamming_acc_param #(
  parameter int N = 32,
  parameter int W = 1
) (
  input logic           clk,
  input logic           rst,
  hamming_acc_param_if.slave bus
);
  localparam int CC = N / W;
  localparam int OW = $clog2(N + 1);
  localparam int BW = $clog2(CC + 1);

  generate
    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_cfg
      $error("hamming_acc_param: N must be a positive multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] o_q, o_d;
  logic [W-1:0]  diff;
  logic [OW-1:0] pc;
  logic [OW-1:0] sum;
  logic          take_beat;
  logic          last_beat;
`ifdef HAMMING_ACC_THRESH_EN
  logic          match_q, match_d;
`endif

  always_comb begin
    diff = bus.g_input ^ bus.e_input;
    pc   = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + OW'(diff[i]);
    end
    sum = o_q + pc;
  end

  // start wins over a coincident beat, so that beat is never counted.
  assign take_beat = !bus.start && (state_q == ST_ACCUM) && bus.in_valid;
  assign last_beat = take_beat && (cnt_q == BW'(CC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
`ifdef HAMMING_ACC_THRESH_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
`ifdef HAMMING_ACC_THRESH_EN
      match_q <= match_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    if (bus.start) begin
      state_d = ST_ACCUM;
      cnt_d   = '0;
      o_d     = '0;
    end else if (take_beat) begin
      o_d   = sum;
      cnt_d = cnt_q + BW'(1);
      if (last_beat) begin
        state_d = ST_DONE;
      end
    end
  end

`ifdef HAMMING_ACC_THRESH_EN
  always_comb begin
    match_d = match_q;
    if (bus.start) begin
      match_d = 1'b0;
    end else if (last_beat) begin
      match_d = (sum <= bus.thresh);
    end
  end
`endif

  always_comb begin
    bus.o         = o_q;
    bus.busy      = (state_q == ST_ACCUM);
    bus.done      = (state_q == ST_DONE);
    bus.state_dbg = state_q;
`ifdef HAMMING_ACC_THRESH_EN
    bus.match     = match_q;
`endif
  end
endmodule

// File: tb/tb_hamming_acc_param.sv
// Bench for hamming_acc_param: a W=1 and a W=8 instance (N=32) checked every cycle
// against a session model built from a queue of per-beat differing-bit counts.
module tb_hamming_acc_param;
  localparam int N  = 32;
  localparam int OW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_acc_param_if #(.N(N), .W(1)) bus1 ();
  hamming_acc_param_if #(.N(N), .W(8)) bus8 ();

  hamming_acc_param #(.N(N), .W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  hamming_acc_param #(.N(N), .W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_vec = 0;
  int n_err = 0;
  logic [OW-1:0] th_cur = '0;

  // Reference model: a session is the list of differing-bit counts of its accepted beats.
  bit m_started[2];
  bit m_match[2];
  int m_q1[$];
  int m_q8[$];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cc_of(input int sel);
    return (sel == 0) ? N : N / 8;
  endfunction

  function automatic int m_size(input int sel);
    return (sel == 0) ? m_q1.size() : m_q8.size();
  endfunction

  function automatic int m_sum(input int sel);
    int s = 0;
    if (sel == 0) foreach (m_q1[i]) s += m_q1[i];
    else          foreach (m_q8[i]) s += m_q8[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_started[s] = 1'b0;
      m_match[s]   = 1'b0;
    end
    m_q1.delete();
    m_q8.delete();
  endtask

  task automatic model_step(input int sel, input bit st, input bit v,
                            input logic [7:0] g, input logic [7:0] e, input int th);
    if (st) begin
      m_started[sel] = 1'b1;
      m_match[sel]   = 1'b0;
      if (sel == 0) m_q1.delete(); else m_q8.delete();
    end else if (m_started[sel] && m_size(sel) < cc_of(sel) && v) begin
      if (sel == 0) m_q1.push_back($countones(g ^ e));
      else          m_q8.push_back($countones(g ^ e));
      if (m_size(sel) == cc_of(sel)) m_match[sel] = (m_sum(sel) <= th);
    end
  endtask

  function automatic bit m_done(input int sel);
    return m_started[sel] && (m_size(sel) == cc_of(sel));
  endfunction

  task automatic check_outputs(input int sel);
    int got_o, got_busy, got_done, got_match;
    got_match = 0;
    if (sel == 0) begin
      got_o = int'(bus1.o); got_busy = int'(bus1.busy); got_done = int'(bus1.done);
`ifdef HAMMING_ACC_THRESH_EN
      got_match = int'(bus1.match);
`endif
    end else begin
      got_o = int'(bus8.o); got_busy = int'(bus8.busy); got_done = int'(bus8.done);
`ifdef HAMMING_ACC_THRESH_EN
      got_match = int'(bus8.match);
`endif
    end
    check($sformatf("o[w%0d]", sel ? 8 : 1), got_o, m_sum(sel));
    check($sformatf("busy[w%0d]", sel ? 8 : 1), got_busy,
          int'(m_started[sel] && m_size(sel) < cc_of(sel)));
    check($sformatf("done[w%0d]", sel ? 8 : 1), got_done, int'(m_done(sel)));
`ifdef HAMMING_ACC_THRESH_EN
    check($sformatf("match[w%0d]", sel ? 8 : 1), got_match, int'(m_match[sel]));
`else
    if (got_match != 0) check("match_absent", got_match, 0);
`endif
  endtask

  // Drive one cycle on the selected instance, advance the model at the edge, then check.
  task automatic beat(input int sel, input bit st, input bit v,
                      input logic [7:0] g, input logic [7:0] e);
    logic [7:0] gm, em;
    gm = (sel == 0) ? {7'b0, g[0]} : g;
    em = (sel == 0) ? {7'b0, e[0]} : e;
    if (sel == 0) begin
      bus1.start = st; bus1.in_valid = v; bus1.g_input = gm[0]; bus1.e_input = em[0];
    end else begin
      bus8.start = st; bus8.in_valid = v; bus8.g_input = gm; bus8.e_input = em;
    end
`ifdef HAMMING_ACC_THRESH_EN
    bus1.thresh = th_cur;
    bus8.thresh = th_cur;
`endif
    @(posedge clk);
    model_step(sel, st, v, gm, em, int'(th_cur));
    #1;
    check_outputs(sel);
    if (sel == 0) begin bus1.start = 1'b0; bus1.in_valid = 1'b0; end
    else          begin bus8.start = 1'b0; bus8.in_valid = 1'b0; end
  endtask

  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) beat(sel, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Random session with random gaps and an occasional abort; bounded in cycles.
  task automatic rand_session(input int sel);
    int guard;
    beat(sel, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    guard = 0;
    while (!m_done(sel) && guard < 400) begin
      beat(sel, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 8'($urandom));
      guard++;
    end
    if (guard >= 400) check("session_timeout", guard, 0);
    idle(sel, 2);
  endtask

  initial begin
    rst = 1'b0;
    bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.g_input = '0; bus1.e_input = '0;
    bus8.start = 1'b0; bus8.in_valid = 1'b0; bus8.g_input = '0; bus8.e_input = '0;
`ifdef HAMMING_ACC_THRESH_EN
    bus1.thresh = '0; bus8.thresh = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst = 1'b1;
    idle(0, 2);

    // W=1: identical inputs -> distance 0, done right after beat 32
    beat(0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      beat(0, 1'b0, 1'b1, r, r);
    end
    check("w1_equal_o", int'(bus1.o), 0);
    check("w1_equal_done", int'(bus1.done), 1);
    idle(0, 3);

    // W=1: every bit differs -> 32
    beat(0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++) beat(0, 1'b0, 1'b1, 8'h01, 8'h00);
    check("w1_all_diff_o", int'(bus1.o), 32);
    idle(0, 2);

    // W=1: alternating bits -> 16
    beat(0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++) beat(0, 1'b0, 1'b1, 8'(i & 1), 8'h00);
    check("w1_alt_o", int'(bus1.o), 16);
    idle(0, 2);

    // W=8: fixed four-beat session, then again with a 3-cycle gap
    for (int pass = 0; pass < 2; pass++) begin
      beat(1, 1'b1, 1'b0, 8'h00, 8'h00);
      beat(1, 1'b0, 1'b1, 8'hFF, 8'h00);
      beat(1, 1'b0, 1'b1, 8'h0F, 8'h00);
      if (pass == 1) idle(1, 3);
      beat(1, 1'b0, 1'b1, 8'hAA, 8'hAA);
      check("w8_busy_before_last", int'(bus8.busy), 1);
      beat(1, 1'b0, 1'b1, 8'h01, 8'h00);
      check("w8_fixed_o", int'(bus8.o), 13);
      check("w8_fixed_done", int'(bus8.done), 1);
      idle(1, 2);
    end

    // W=8: abort with start+in_valid; the coincident beat must not count
    beat(1, 1'b1, 1'b0, 8'h00, 8'h00);
    beat(1, 1'b0, 1'b1, 8'hFF, 8'h00);
    beat(1, 1'b0, 1'b1, 8'hFF, 8'h00);
    beat(1, 1'b1, 1'b1, 8'hFF, 8'h00);
    check("w8_abort_o", int'(bus8.o), 0);
    for (int i = 0; i < 4; i++) beat(1, 1'b0, 1'b1, 8'h01, 8'h00);
    check("w8_abort_final_o", int'(bus8.o), 4);
    idle(1, 2);

    // Asynchronous reset mid-session, observed before the next edge
    beat(1, 1'b1, 1'b0, 8'h00, 8'h00);
    beat(1, 1'b0, 1'b1, 8'hFF, 8'h00);
    beat(1, 1'b0, 1'b1, 8'h3C, 8'h00);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_async_o", int'(bus8.o), 0);
    check("rst_async_busy", int'(bus8.busy), 0);
    check("rst_async_done", int'(bus8.done), 0);
    check_outputs(0);
    #1;
    rst = 1'b1;
    idle(1, 1);
    rand_session(1);

    // Random sessions on both widths
    for (int k = 0; k < 6; k++) begin
      rand_session(0);
      rand_session(1);
    end

`ifdef HAMMING_ACC_THRESH_EN
    th_cur = OW'(10);
    for (int d = 10; d <= 11; d++) begin
      beat(0, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 32; i++) beat(0, 1'b0, 1'b1, 8'(i < d), 8'h00);
      check($sformatf("thresh_match_d%0d", d), int'(bus1.match), (d <= 10) ? 1 : 0);
      idle(0, 2);
    end
    beat(0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 32; i++) beat(0, 1'b0, 1'b1, 8'h00, 8'h00);
    check("thresh_match_zero", int'(bus1.match), 1);
    beat(0, 1'b1, 1'b0, 8'h00, 8'h00);
    check("thresh_match_cleared", int'(bus1.match), 0);
    idle(0, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
